// File: rtl/bf_pkg.sv
// -----------------------------------------------------------------------------
// bf_pkg -- shared definitions for the pixel fetch block.
//   IMG_W / IMG_H : default frame geometry (pixels per row / rows per frame)
//   ADDR_W        : image memory address width
//   PIX_W         : pixel width
//   fetch_state_t : pixel_fetch FSM states
//   pixel_t       : pixel record carried through the output FIFO
// -----------------------------------------------------------------------------
package bf_pkg;

    localparam int unsigned IMG_W  = 256;
    localparam int unsigned IMG_H  = 256;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned PIX_W  = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic [7:0]       x;
        logic [7:0]       y;
        logic             last;
    } pixel_t;

endpackage

// File: rtl/pixel_fetch_fifo.sv
// -----------------------------------------------------------------------------
// pixel_fifo -- synchronous FIFO for pixel records.
// Parameters:
//   DEPTH : number of entries (power of two, >= 2)
//   T     : entry type
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_push, i_data  : write request and entry (ignored when full without pop)
//   i_pop           : read request (ignored when empty)
//   o_data          : head entry
//   o_full, o_empty : status flags
//   o_count         : current occupancy
// Push and pop in the same cycle on a full FIFO is accepted.
// -----------------------------------------------------------------------------
module pixel_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = logic [7:0]
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  T                         i_data,
    input  logic                     i_pop,
    output T                         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd];
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr <= r_wr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd <= r_rd + PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_fetch.sv
// -----------------------------------------------------------------------------
// pixel_fetch -- reads a frame from image memory in raster order and streams
// it to a downstream filter core through a small FIFO with valid/ready.
// Parameters:
//   DEPTH : output FIFO entries (power of two, >= 2)
//   IMG_W : pixels per row
//   IMG_H : rows per frame
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : image memory readable
//   in_addr    : read address (sampled by the memory on the rising edge)
//   in_data    : pixel for the address issued on the previous rising edge
//   px_valid / px_ready : output handshake
//   px_data, px_x, px_y, px_last : FIFO head pixel (zero while empty)
//   done       : whole frame delivered, held until reset
//   fetch_sum  : running sum of delivered pixels (only with PIXEL_FETCH_SUM_EN)
// Optional feature macro: PIXEL_FETCH_SUM_EN
// -----------------------------------------------------------------------------
module pixel_fetch
    import bf_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IMG_W = bf_pkg::IMG_W,
    parameter int unsigned IMG_H = bf_pkg::IMG_H
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic [15:0]       in_addr,
    input  logic [7:0]        in_data,
    output logic              px_valid,
    input  logic              px_ready,
    output logic [7:0]        px_data,
    output logic [7:0]        px_x,
    output logic [7:0]        px_y,
    output logic              px_last,
    output logic              done
`ifdef PIXEL_FETCH_SUM_EN
    ,
    output logic [23:0]       fetch_sum
`endif
);

    localparam int unsigned     NPIX      = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam int unsigned     CNT_W     = $clog2(DEPTH) + 1;

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_fl_addr;
    logic              r_inflight;

    logic              w_issue;
    logic              w_pop;
    logic              w_can_issue;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W:0]    w_pending;
    pixel_t            w_push_px;
    pixel_t            w_head;

    assign w_pop = !w_empty && px_ready;

    // Occupancy after this edge plus the read in flight: the popped slot is
    // credited now so the stream sustains one pixel per cycle at DEPTH=2.
    assign w_pending   = {1'b0, w_count} + (CNT_W+1)'(r_inflight) - (CNT_W+1)'(w_pop);
    assign w_can_issue = w_pending < (CNT_W+1)'(DEPTH);

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE, S_FETCH: begin
                if (in_valid && w_can_issue) begin
                    w_issue     = 1'b1;
                    w_state_nxt = (r_addr == LAST_ADDR) ? S_DRAIN : S_FETCH;
                end
            end
            S_DRAIN: begin
                // Final pixel leaving the FIFO empties it: nothing follows it.
                if (w_pop && w_head.last) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = r_state;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_fl_addr  <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fl_addr <= r_addr;
                if (r_addr != LAST_ADDR) begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
            end
        end
    end

    assign w_push_px.data = in_data;
    assign w_push_px.x    = r_fl_addr[7:0];
    assign w_push_px.y    = r_fl_addr[15:8];
    assign w_push_px.last = (r_fl_addr == LAST_ADDR);

    pixel_fifo #(
        .DEPTH (DEPTH),
        .T     (pixel_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_data  (w_push_px),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign in_addr  = r_addr;
    assign px_valid = !w_empty;
    assign px_data  = w_empty ? '0 : w_head.data;
    assign px_x     = w_empty ? '0 : w_head.x;
    assign px_y     = w_empty ? '0 : w_head.y;
    assign px_last  = !w_empty && w_head.last;
    assign done     = (r_state == S_DONE);

`ifdef PIXEL_FETCH_SUM_EN
    logic [23:0] r_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= '0;
        end else if (w_pop) begin
            r_sum <= r_sum + 24'(w_head.data);
        end
    end

    assign fetch_sum = r_sum;
`endif

endmodule

// File: tb/tb_pixel_fetch.sv
// -----------------------------------------------------------------------------
// tb_pixel_fetch -- directed bench for pixel_fetch on a 256x4 frame.
// Memory model: synchronous read, in_data <= image(in_addr) each rising edge.
// -----------------------------------------------------------------------------
module tb_pixel_fetch;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned W     = 256;
    localparam int unsigned H     = 4;
    localparam int          N     = W * H;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_addr;
    logic [7:0]  in_data;
    logic        px_valid;
    logic        px_ready;
    logic [7:0]  px_data;
    logic [7:0]  px_x;
    logic [7:0]  px_y;
    logic        px_last;
    logic        done;
`ifdef PIXEL_FETCH_SUM_EN
    logic [23:0] fetch_sum;
`endif

    pixel_fetch #(
        .DEPTH (DEPTH),
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .px_valid (px_valid),
        .px_ready (px_ready),
        .px_data  (px_data),
        .px_x     (px_x),
        .px_y     (px_y),
        .px_last  (px_last),
        .done     (done)
`ifdef PIXEL_FETCH_SUM_EN
        ,
        .fetch_sum (fetch_sum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: ramp image, 1: constant 255, 2: all zero
    int mem_mode = 0;

    always @(posedge clk) begin
        case (mem_mode)
            1:       in_data <= 8'hFF;
            2:       in_data <= 8'h00;
            default: in_data <= in_addr[7:0];
        endcase
    end

    int          n_vec = 0;
    int          n_err = 0;
    int          exp_k;
    int          tcount;
    int          first_v;
    int          gap_seen;
    bit          mon_en;
    bit          stall_prev;
    logic [24:0] prev_bus;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_pix(input int k);
        logic [31:0] kv;
        kv = k;
        case (mem_mode)
            1:       return 8'hFF;
            2:       return 8'h00;
            default: return kv[7:0];
        endcase
    endfunction

    // Output checks at the falling edge, with this cycle's inputs applied.
    task automatic mon();
        logic [31:0] kv;
        if (!mon_en) return;
        if (px_valid && first_v < 0) first_v = tcount;
        if (stall_prev) begin
            chk("hold_valid", px_valid, 1);
            chk("hold_bus", {px_data, px_x, px_y, px_last}, prev_bus);
        end
        if (px_valid && px_ready) begin
            kv = exp_k;
            chk("px_data", px_data, exp_pix(exp_k));
            chk("px_x", px_x, kv[7:0]);
            chk("px_y", px_y, kv[15:8]);
            chk("px_last", px_last, (exp_k == N - 1) ? 1 : 0);
            exp_k++;
        end
        stall_prev = px_valid && !px_ready;
        prev_bus   = {px_data, px_x, px_y, px_last};
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
        tcount++;
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_addr"},  in_addr,  0);
        chk({tag, "_valid"}, px_valid, 0);
        chk({tag, "_data"},  px_data,  0);
        chk({tag, "_x"},     px_x,     0);
        chk({tag, "_y"},     px_y,     0);
        chk({tag, "_last"},  px_last,  0);
        chk({tag, "_done"},  done,     0);
    endtask

    task automatic do_reset();
        mon_en   = 0;
        rst      = 1;
        in_valid = 0;
        tick();
        rst      = 0;
    endtask

    task automatic new_frame();
        exp_k      = 0;
        tcount     = 0;
        first_v    = -1;
        gap_seen   = 0;
        stall_prev = 0;
        mon_en     = 1;
    endtask

    // rmode 0: ready held high, 1: ready random 50%.
    // gap_at >= 0: drop in_valid for 10 cycles once in_addr reaches gap_at.
    // stop_at >= 0: return once that many pixels have been accepted.
    task automatic run_frame(input int rmode, input int gap_at, input int stop_at, output int cyc);
        int gap_left;
        gap_left = 10;
        cyc      = 0;
        while (!done && cyc < 5 * N + 100 && exp_k != stop_at) begin
            px_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (gap_at >= 0 && int'(in_addr) == gap_at && gap_left > 0) begin
                in_valid = 0;
                gap_left--;
            end else begin
                in_valid = 1;
            end
            tick();
            if (!in_valid) begin
                gap_seen++;
                chk("gap_addr", in_addr, gap_at);
            end
            cyc++;
        end
        if (cyc >= 5 * N + 100) chk("timeout", 0, 1);
    endtask

    int cyc;

    initial begin
        rst      = 1;
        in_valid = 0;
        px_ready = 0;
        mon_en   = 0;
        @(posedge clk);
        #1;
        tick();
        tick();
        chk_rst("por");
        rst = 0;

        // IDLE waits for in_valid
        tick();
        tick();
        chk("idle_addr", in_addr, 0);
        chk("idle_valid", px_valid, 0);

        // Ramp frame, ready held high
        new_frame();
        run_frame(0, -1, -1, cyc);
        chk("ramp_first_latency", first_v, 2);
        chk("ramp_cycles", cyc, N + 2);
        chk("ramp_count", exp_k, N);
        chk("ramp_done", done, 1);

        // DONE ignores inputs; address does not wrap
        for (int i = 0; i < 5; i++) begin
            in_valid = 1;
            px_ready = 1'($urandom_range(0, 1));
            tick();
            chk("post_done", done, 1);
            chk("post_valid", px_valid, 0);
            chk("post_addr", in_addr, N - 1);
        end
        do_reset();
        chk_rst("rst_after_done");

        // Random backpressure
        new_frame();
        run_frame(1, -1, -1, cyc);
        chk("rand_count", exp_k, N);
        chk("rand_done", done, 1);

        // Ready low for 20 cycles: exactly DEPTH reads, then issue stalls
        do_reset();
        new_frame();
        in_valid = 1;
        px_ready = 0;
        for (int i = 0; i < 20; i++) tick();
        chk("stall_addr", in_addr, DEPTH);
        chk("stall_valid", px_valid, 1);
        chk("stall_data", px_data, 0);
        run_frame(0, -1, -1, cyc);
        chk("stall_count", exp_k, N);
        chk("stall_done", done, 1);

        // in_valid gap at pixel 1000
        do_reset();
        new_frame();
        run_frame(0, 1000, -1, cyc);
        chk("gap_len", gap_seen, 10);
        chk("gap_count", exp_k, N);
        chk("gap_done", done, 1);

        // Reset mid-frame, then a clean restart
        do_reset();
        new_frame();
        run_frame(0, -1, 300, cyc);
        chk("mid_reached", exp_k, 300);
        do_reset();
        chk_rst("mid_rst");
        new_frame();
        run_frame(0, -1, -1, cyc);
        chk("restart_count", exp_k, N);
        chk("restart_done", done, 1);

`ifdef PIXEL_FETCH_SUM_EN
        do_reset();
        chk("sum_rst", fetch_sum, 0);
        mem_mode = 1;
        new_frame();
        run_frame(0, -1, -1, cyc);
        chk("sum_255", fetch_sum, 255 * N);
        do_reset();
        mem_mode = 2;
        new_frame();
        run_frame(1, -1, -1, cyc);
        chk("sum_zero", fetch_sum, 0);
        mem_mode = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pixel_fetch.md
PIXEL_FETCH -- requirements
Module: pixel_fetch

Interface
REQ-001 Parameter DEPTH, default 4: output FIFO entries, power of two, minimum 2.
REQ-002 Parameter IMG_W, default 256: pixels per row.
REQ-003 Parameter IMG_H, default 256: rows per frame.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  image memory readable; level, high for the whole run.
REQ-007 in_addr  output  16  read address into image memory.
REQ-008 in_data  input  8  pixel at the in_addr issued on the previous rising edge.
REQ-009 px_valid  output  1  px_* holds a pixel.
REQ-010 px_ready  input  1  downstream filter core accepts pixel.
REQ-011 px_data  output  8  pixel value.
REQ-012 px_x  output  8  column, equal to address[7:0].
REQ-013 px_y  output  8  row, equal to address[15:8].
REQ-014 px_last  output  1  high with pixel IMG_W*IMG_H-1.
REQ-015 done  output  1  all pixels delivered; held high until reset.

Function
REQ-016 FSM states: IDLE, FETCH, DRAIN, DONE.
REQ-017 IDLE->FETCH when in_valid=1; in_addr=0 is issued in that same cycle.
REQ-018 Read issue: an address is issued only in FETCH, only when in_valid=1, and only when FIFO occupancy plus reads in flight is less than DEPTH.
REQ-019 Issued addresses run in raster order 0..IMG_W*IMG_H-1, each exactly once; in_addr holds its last value while no read is issued.
REQ-020 Read latency: in_data is captured into the FIFO on the rising edge after the issue, together with its address.
REQ-021 A read in flight is always captured, even if in_valid falls in that cycle.
REQ-022 After the final address is issued, FSM goes FETCH->DRAIN; the address counter does not wrap.
REQ-023 DRAIN->DONE when the FIFO is empty and the px_last pixel has been accepted; done rises that cycle.
REQ-024 Handshake: transfer when px_valid=1 and px_ready=1.
REQ-025 px_valid never drops, and px_* never change, until a transfer occurs.
REQ-026 px_* shows the FIFO head. First pixel latency: px_valid rises 2 cycles after the first issue.
REQ-027 Push and pop in the same cycle on a full FIFO is legal; occupancy stays unchanged.
REQ-028 Throughput: with px_ready held at 1, one pixel per cycle; a frame of N pixels completes within N+3 cycles of leaving IDLE.
REQ-029 in_valid low in FETCH pauses issue only; delivery of queued pixels continues.
REQ-030 DONE is terminal; in_valid and px_ready are ignored until reset.

Reset
REQ-031 When rst=1 at a rising edge, the block returns to the following values regardless of the current state, including mid-frame:
- in_addr=0, px_valid=0, px_data=0, px_x=0, px_y=0, px_last=0, done=0
- FIFO empty, in-flight flag cleared, FSM=IDLE.
REQ-032 Memory data returning in the cycle after reset is discarded.

Configuration
REQ-033 Macro PIXEL_FETCH_SUM_EN, when defined:
- adds output fetch_sum [23:0], reset to 0;
- fetch_sum adds px_data on every transfer;
- fetch_sum is final when done=1 (max 65536*255 fits in 24 bits).
REQ-034 Without PIXEL_FETCH_SUM_EN the port and adder are absent; all other behaviour is identical.

Structure
REQ-035 Shared package bf_pkg holds:
- IMG_W, IMG_H, ADDR_W=16, PIX_W=8;
- the FSM state enum;
- a pixel record typedef {data, x, y, last}.
REQ-036 Sub-module pixel_fifo: synchronous FIFO parameterised by DEPTH and record type, with full, empty and count outputs. The FSM and address counter live in pixel_fetch.

Verification
REQ-037 Ramp image, mem[a]=a[7:0], px_ready=1 -> 65536 transfers in order; pixel k has data=k%256, x=k%256, y=k/256; px_last only on k=65535; done by cycle 65539.
REQ-038 px_ready toggled randomly at 50% -> same ordered sequence, no drop or duplicate, px_* stable while stalled; max occupancy+inflight never exceeds DEPTH.
REQ-039 px_ready=0 for 20 cycles after start -> exactly DEPTH reads issued, then issue stalls; on release, stream resumes from pixel 0 intact.
REQ-040 in_valid deasserted for 10 cycles at pixel 1000 -> no new addresses issued during the gap; sequence continues at 1001 with no gap in data.
REQ-041 rst pulsed at pixel 30000 -> next cycle all outputs at reset values; a new run restarts at address 0 with correct data.
REQ-042 With PIXEL_FETCH_SUM_EN, constant image of 255 -> fetch_sum=16711680 at done; all-zero image -> 0.
